multicycle_controller: RTL

Microsequencer FSM that drives every load, tristate, mux-select and register-bank strobe of the multicycle CPU datapath, one micro-step per clock. It decodes the opcode bits irContr[6:0] (IR[15:9]) and the branch condition result Dcondn. It runs fetch / decode / execute sequences for ALU, LOAD, STORE, BRANCH and HALT instructions. It also owns the external memory handshake: mem_rd or mem_wr is held until mem_ready is sampled.

---
 rtl/mc_pkg.sv | 40 ++++
 rtl/mc_wait_timer.sv | 30 +++
 rtl/multicycle_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle CPU microsequencer: state codes, opcode
// classes, ALU function selects and register read-port selects.
package mc_pkg;

   localparam int STATE_W = 5;

   localparam logic [STATE_W-1:0] ST_RST  = 5'd0;
   localparam logic [STATE_W-1:0] ST_F0   = 5'd1;
   localparam logic [STATE_W-1:0] ST_F1   = 5'd2;
   localparam logic [STATE_W-1:0] ST_F2   = 5'd3;
   localparam logic [STATE_W-1:0] ST_D    = 5'd4;
   localparam logic [STATE_W-1:0] ST_A0   = 5'd5;
   localparam logic [STATE_W-1:0] ST_A1   = 5'd6;
   localparam logic [STATE_W-1:0] ST_L0   = 5'd7;
   localparam logic [STATE_W-1:0] ST_L1   = 5'd8;
   localparam logic [STATE_W-1:0] ST_L2   = 5'd9;
   localparam logic [STATE_W-1:0] ST_L3   = 5'd10;
   localparam logic [STATE_W-1:0] ST_S0   = 5'd11;
   localparam logic [STATE_W-1:0] ST_S1   = 5'd12;
   localparam logic [STATE_W-1:0] ST_S2   = 5'd13;
   localparam logic [STATE_W-1:0] ST_S3   = 5'd14;
   localparam logic [STATE_W-1:0] ST_B0   = 5'd15;
   localparam logic [STATE_W-1:0] ST_B1   = 5'd16;
   localparam logic [STATE_W-1:0] ST_HALT = 5'd17;

   // Opcode classes on IR[15:13]; any class with the top bit clear is ALU.
   localparam logic [2:0] OPC_LOAD   = 3'b100;
   localparam logic [2:0] OPC_STORE  = 3'b101;
   localparam logic [2:0] OPC_BRANCH = 3'b110;
   localparam logic [2:0] OPC_HALT   = 3'b111;

   localparam logic [1:0] FN_IR   = 2'd0;
   localparam logic [1:0] FN_ADD  = 2'd1;
   localparam logic [1:0] FN_PASS = 2'd2;

   localparam logic [1:0] SEL_RB = 2'd0;
   localparam logic [1:0] SEL_RX = 2'd1;
   localparam logic [1:0] SEL_RD = 2'd2;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter: clears outside wait states, counts cycles without mem_ready.
// Latency: timeout is combinational on the cycle the count would reach MEM_TIMEOUT; no backpressure.
module mc_wait_timer #(
   parameter int MEM_TIMEOUT = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic in_wait,
   input  logic mem_ready,
   output logic timeout
);

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !in_wait) begin
         cnt <= '0;
      end else if (!mem_ready) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Fires on the wait cycle whose increment would make the count hit
   // MEM_TIMEOUT; a simultaneous mem_ready takes priority.
   assign timeout = (MEM_TIMEOUT != 0) && in_wait && !mem_ready && (cnt == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Microsequencer driving all multicycle datapath strobes, one micro-step per clock.
// Latency: Moore outputs from state; memory wait states hold mem_rd/mem_wr until mem_ready.
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       irContr,
   input  logic             Dcondn,
   input  logic             mem_ready,
   output logic             rd,
   output logic             wr,
   output logic             LPC,
   output logic             TPC,
   output logic             LT,
   output logic             TT,
   output logic             LMAR,
   output logic             TMAR,
   output logic             LIR,
   output logic             RMDRExt,
   output logic             RMDRInt,
   output logic             TMDR2X,
   output logic             TMDR2Ext,
   output logic             TMDR2IR,
   output logic             LMDR,
   output logic             LregY,
   output logic             T1,
   output logic             Lflag,
   output logic             PCrst,
   output logic [1:0]       fnSel,
   output logic [1:0]       selreg,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             halted,
   output logic             mem_fault,
   output logic [CNT_W-1:0] instr_count
);

   logic [STATE_W-1:0] state, state_nxt;
   logic               in_wait, timeout, retire;
   logic               unused_ir;

   assign unused_ir = ^irContr[3:0];

   assign in_wait = (state == ST_F1) || (state == ST_L2) || (state == ST_S3);
   assign retire  = (state == ST_A1) || (state == ST_L3) || (state == ST_B1) ||
                    ((state == ST_S3) && mem_ready);

   mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .in_wait   (in_wait),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RST:  state_nxt = ST_F0;
         ST_F0:   state_nxt = ST_F1;
         ST_F1:   state_nxt = mem_ready ? ST_F2 : (timeout ? ST_HALT : ST_F1);
         ST_F2:   state_nxt = ST_D;
         ST_D: begin
            if (!irContr[6]) begin
               state_nxt = ST_A0;
            end else begin
               case (irContr[6:4])
                  OPC_LOAD:   state_nxt = ST_L0;
                  OPC_STORE:  state_nxt = ST_S0;
                  OPC_BRANCH: state_nxt = ST_B0;
                  default:    state_nxt = ST_HALT;
               endcase
            end
         end
         ST_A0:   state_nxt = ST_A1;
         ST_A1:   state_nxt = ST_F0;
         ST_L0:   state_nxt = ST_L1;
         ST_L1:   state_nxt = ST_L2;
         ST_L2:   state_nxt = mem_ready ? ST_L3 : (timeout ? ST_HALT : ST_L2);
         ST_L3:   state_nxt = ST_F0;
         ST_S0:   state_nxt = ST_S1;
         ST_S1:   state_nxt = ST_S2;
         ST_S2:   state_nxt = ST_S3;
         ST_S3:   state_nxt = mem_ready ? ST_F0 : (timeout ? ST_HALT : ST_S3);
         ST_B0:   state_nxt = ST_B1;
         ST_B1:   state_nxt = ST_F0;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RST;
         instr_count <= '0;
         mem_fault   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (retire) begin
            instr_count <= instr_count + 1'b1;
         end
         if (timeout) begin
            mem_fault <= 1'b1;
         end
      end
   end

   // LT, TT and TMDR2IR are never used by this instruction set.
   assign LT      = 1'b0;
   assign TT      = 1'b0;
   assign TMDR2IR = 1'b0;

   always_comb begin
      rd = 1'b0;  wr = 1'b0;  LPC = 1'b0;  TPC = 1'b0;
      LMAR = 1'b0;  TMAR = 1'b0;  LIR = 1'b0;
      RMDRExt = 1'b0;  RMDRInt = 1'b0;  TMDR2X = 1'b0;  TMDR2Ext = 1'b0;
      LMDR = 1'b0;  LregY = 1'b0;  T1 = 1'b0;  Lflag = 1'b0;  PCrst = 1'b0;
      fnSel = FN_IR;  selreg = SEL_RB;
      mem_rd = 1'b0;  mem_wr = 1'b0;  halted = 1'b0;
      case (state)
         ST_RST:  PCrst = 1'b1;
         ST_F0: begin
            TPC = 1'b1;  fnSel = FN_PASS;  LMAR = 1'b1;  LregY = 1'b1;
         end
         ST_F1: begin
            TMAR = 1'b1;  mem_rd = 1'b1;  LIR = mem_ready;
         end
         ST_F2: begin
            T1 = 1'b1;  fnSel = FN_ADD;  LPC = 1'b1;
         end
         ST_A0, ST_L0, ST_S0: begin
            selreg = SEL_RB;  rd = 1'b1;  LregY = 1'b1;
         end
         ST_A1: begin
            selreg = SEL_RX;  rd = 1'b1;  fnSel = FN_IR;  Lflag = 1'b1;  wr = 1'b1;
         end
         ST_L1, ST_S1: begin
            selreg = SEL_RX;  rd = 1'b1;  fnSel = FN_ADD;  LMAR = 1'b1;
         end
         ST_L2: begin
            TMAR = 1'b1;  mem_rd = 1'b1;  RMDRExt = 1'b1;  LMDR = mem_ready;
         end
         ST_L3: begin
            TMDR2X = 1'b1;  fnSel = FN_PASS;  wr = 1'b1;
         end
         ST_S2: begin
            selreg = SEL_RD;  rd = 1'b1;  fnSel = FN_PASS;  RMDRInt = 1'b1;  LMDR = 1'b1;
         end
         ST_S3: begin
            TMAR = 1'b1;  TMDR2Ext = 1'b1;  mem_wr = 1'b1;
         end
         ST_B0: begin
            TPC = 1'b1;  LregY = 1'b1;
         end
         ST_B1: begin
            if (Dcondn) begin
               selreg = SEL_RB;  rd = 1'b1;  fnSel = FN_ADD;  LPC = 1'b1;
            end
         end
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule
